// File: rtl/reg_writeback_queue.sv
// Writeback queue: in-order FIFO feeding a register file, one write per two cycles.
// Optional bypass snooping of the read ports is enabled with macro REG_WB_BYPASS_EN.
module reg_writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        elk,
    input  logic        nrst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_addr,
    input  logic [31:0] in_data,
    input  logic        flush,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    input  logic [4:0]  rd_addrA,
    input  logic [4:0]  rd_addrB,
    output logic        byp_hitA,
    output logic [31:0] byp_dataA,
    output logic        byp_hitB,
    output logic [31:0] byp_dataB,
    output logic [4:0]  count,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    state_t        state, state_nxt;
    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          accept, push, pop;

    assign in_ready = nrst && (count < 5'(DEPTH));
    assign accept   = in_valid && in_ready && !flush;
    assign push     = accept && (in_addr != '0);
    assign wr_en    = (state == WRITE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = WRITE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE:   state_nxt = GAP;
            default: state_nxt = IDLE;
        endcase
        // Flush overrides everything, including a pop on the same edge.
        if (flush) begin
            pop       = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge elk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge elk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge elk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                wr_addr <= addr_mem[rd_ptr];
                wr_data <= data_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (accept && (in_addr == '0) && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef REG_WB_BYPASS_EN
    // Scan oldest to youngest so the last match wins; the in-flight entry is oldest of all.
    function automatic logic [32:0] lookup(input logic [4:0] a);
        logic [32:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        if (a != '0) begin
            if ((state != IDLE) && (wr_addr == a)) res = {1'b1, wr_data};
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if ((5'(i) < count) && (addr_mem[idx] == a))
                    res = {1'b1, data_mem[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {byp_hitA, byp_dataA} = lookup(rd_addrA);
        {byp_hitB, byp_dataB} = lookup(rd_addrB);
    end
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addrA, rd_addrB};
    assign byp_hitA  = 1'b0;
    assign byp_dataA = '0;
    assign byp_hitB  = 1'b0;
    assign byp_dataB = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: random and directed pushes against a queue-based model.
module tb_reg_writeback_queue;

    localparam int unsigned DEPTH = 4;

    logic        elk = 1'b0;
    logic        nrst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        flush = 1'b0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addrA = '0;
    logic [4:0]  rd_addrB = '0;
    logic        byp_hitA, byp_hitB;
    logic [31:0] byp_dataA, byp_dataB;
    logic [4:0]  count;
    logic [7:0]  drop_cnt;

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .elk(elk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .byp_hitA(byp_hitA), .byp_dataA(byp_dataA),
        .byp_hitB(byp_hitB), .byp_dataB(byp_dataB),
        .count(count), .drop_cnt(drop_cnt)
    );

    always #5 elk = ~elk;

    typedef struct { logic [4:0] addr; logic [31:0] data; } wb_t;

    wb_t         exp_q[$];
    int          exp_drop = 0;
    logic        inflight = 1'b0;
    int          inflight_age = 0;
    wb_t         inflight_e;
    logic        prev_wr_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest pending value for an address: in-flight first, then queue oldest->youngest.
    function automatic logic [32:0] model_byp(input logic [4:0] a);
        logic [32:0] r;
        r = '0;
        if (a != 0) begin
            if (inflight && inflight_e.addr == a) r = {1'b1, inflight_e.data};
            foreach (exp_q[i]) if (exp_q[i].addr == a) r = {1'b1, exp_q[i].data};
        end
        return r;
    endfunction

    // Request side of the model: what the queue accepts on each edge.
    always @(posedge elk) begin
        if (nrst) begin
            if (flush) begin
                exp_q.delete();
                inflight = 1'b0;
            end else if (in_valid && in_ready) begin
                if (in_addr == 0) begin
                    if (exp_drop < 255) exp_drop++;
                end else begin
                    exp_q.push_back('{addr: in_addr, data: in_data});
                end
            end
        end
    end

    // Monitor: every write strobe pops one expected entry; occupancy and bypass checked each cycle.
    always @(negedge elk) begin
        logic [32:0] eb;
        wb_t e;
        if (wr_en) begin
            check("wr_en_one_cycle", {31'b0, prev_wr_en}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {27'b0, wr_addr}, {27'b0, e.addr});
                check("wr_data", wr_data, e.data);
                inflight = 1'b1;
                inflight_age = 0;
                inflight_e = e;
            end
        end else if (inflight) begin
            inflight_age++;
            if (inflight_age >= 2) inflight = 1'b0;
        end
        prev_wr_en = wr_en;
        check("count", {27'b0, count}, exp_q.size());
        check("in_ready", {31'b0, in_ready}, {31'b0, (nrst && exp_q.size() < DEPTH)});
        check("drop_cnt", {24'b0, drop_cnt}, exp_drop);
`ifdef REG_WB_BYPASS_EN
        eb = model_byp(rd_addrA);
        check("byp_hitA", {31'b0, byp_hitA}, {31'b0, eb[32]});
        if (eb[32]) check("byp_dataA", byp_dataA, eb[31:0]);
        eb = model_byp(rd_addrB);
        check("byp_hitB", {31'b0, byp_hitB}, {31'b0, eb[32]});
        if (eb[32]) check("byp_dataB", byp_dataB, eb[31:0]);
`else
        eb = '0;
        check("byp_off", {30'b0, byp_hitA, byp_hitB} | byp_dataA | byp_dataB, {1'b0, eb[30:0]});
`endif
    end

    // Drive one cycle of request signals, starting just after an edge.
    task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d, input logic f);
        in_valid = v; in_addr = a; in_data = d; flush = f;
        @(posedge elk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || inflight) && n < 200) begin
            @(posedge elk); #1;
            n++;
        end
        check("drain_timeout", {31'b0, (exp_q.size() != 0 || inflight)}, 32'd0);
        repeat (2) begin @(posedge elk); #1; end
    endtask

    initial begin
        repeat (2) @(posedge elk);
        #1;
        check("rst_wr_en", {31'b0, wr_en}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        nrst = 1'b1;
        @(posedge elk); #1;

        // Single write latency
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        @(negedge elk);
        check("lat_n_wr_en", {31'b0, wr_en}, 32'd0);
        @(negedge elk);
        check("lat_n1_wr_en", {31'b0, wr_en}, 32'd1);
        check("lat_n1_addr", {27'b0, wr_addr}, 32'd5);
        check("lat_n1_data", wr_data, 32'hDEADBEEF);
        @(negedge elk);
        check("lat_n2_wr_en", {31'b0, wr_en}, 32'd0);
        check("lat_n2_hold", wr_data, 32'hDEADBEEF);
        @(posedge elk); #1;
        wait_drain();

        // Fill: five back-to-back pushes
        for (int i = 0; i < 5; i++) cyc(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'(i + 10), 32'h200 + 32'(i), 1'b0);
        wait_drain();

        // Register 0 drops
        cyc(1'b1, 5'd0, 32'h1, 1'b0);
        cyc(1'b1, 5'd0, 32'h2, 1'b0);
        cyc(1'b1, 5'd7, 32'h3, 1'b0);
        wait_drain();
        check("drop_two", {24'b0, drop_cnt}, 32'd2);

        // Flush while in WRITE, with a same-edge push
        cyc(1'b1, 5'd1, 32'hA, 1'b0);
        cyc(1'b1, 5'd2, 32'hB, 1'b0);
        cyc(1'b1, 5'd3, 32'hC, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        check("flush_pre_wr_en", {31'b0, wr_en}, 32'd1);
        cyc(1'b1, 5'd4, 32'hD, 1'b1);
        check("flush_count", {27'b0, count}, 32'd0);
        check("flush_wr_en", {31'b0, wr_en}, 32'd0);
        wait_drain();

`ifdef REG_WB_BYPASS_EN
        cyc(1'b1, 5'd9, 32'h11, 1'b0);
        cyc(1'b1, 5'd9, 32'h22, 1'b0);
        rd_addrA = 5'd9; rd_addrB = 5'd0;
        #1;
        check("byp_dir_hitA", {31'b0, byp_hitA}, 32'd1);
        check("byp_dir_dataA", byp_dataA, 32'h22);
        check("byp_dir_hitB", {31'b0, byp_hitB}, 32'd0);
        wait_drain();
`endif

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rd_addrA = 5'($urandom_range(0, 7));
            rd_addrB = 5'($urandom_range(0, 7));
            cyc($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 49) == 0);
        end
        wait_drain();

        // Async reset mid-GAP with two entries queued
        cyc(1'b1, 5'd11, 32'h31, 1'b0);
        cyc(1'b1, 5'd12, 32'h32, 1'b0);
        cyc(1'b1, 5'd13, 32'h33, 1'b0);
        check("pre_rst_count", {27'b0, count}, 32'd2);
        check("pre_rst_gap", {31'b0, wr_en}, 32'd0);
        #1;
        nrst = 1'b0;
        exp_q.delete();
        inflight = 1'b0;
        exp_drop = 0;
        #1;
        check("arst_wr_en", {31'b0, wr_en}, 32'd0);
        check("arst_wr_addr", {27'b0, wr_addr}, 32'd0);
        check("arst_wr_data", wr_data, 32'd0);
        check("arst_count", {27'b0, count}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd0);
        check("arst_drop", {24'b0, drop_cnt}, 32'd0);
        repeat (2) @(posedge elk);
        #1;
        nrst = 1'b1;
        repeat (10) begin @(posedge elk); #1; end

        // Drop counter saturation
        for (int i = 0; i < 258; i++) cyc(1'b1, 5'd0, 32'(i), 1'b0);
        check("drop_saturate", {24'b0, drop_cnt}, 32'd255);
        repeat (3) begin @(posedge elk); #1; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
